data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 56 +++++
 rtl/data_memory_array.sv | 30 +++
 rtl/data_memory.sv | 101 ++++++++++
 tb/tb_data_memory.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants, state encoding and lane helpers for data_memory
package data_memory_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int READ_REQ_BIT  = 3;
  localparam int WRITE_REQ_BIT = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  // Reserved store size 11 falls into the word case.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      F3_SB:   lane_mask = 4'b0001 << offs;
      F3_SH:   lane_mask = offs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      F3_SB:   store_lanes = {4{data[7:0]}};
      F3_SH:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  // Reserved load funct3 values fall into the word case.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] offs,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offs, 3'b000} +: 8];
    h = offs[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   load_extend = {{24{b[7]}}, b};
      F3_LH:   load_extend = {{16{h[15]}}, h};
      F3_LBU:  load_extend = {24'h0, b};
      F3_LHU:  load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - word-organised byte storage with lane write enables and registered read
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic [ADDR_WIDTH-3:0] i_waddr,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wdata,
  input  logic [ADDR_WIDTH-3:0] i_raddr,
  output logic [31:0]           o_rdata
);

  localparam int WORDS = 1 << (ADDR_WIDTH - 2);

  logic [3:0][7:0] r_mem [WORDS];
  logic [31:0]     r_rdata;

  // No reset: contents survive RESET.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_we[l]) r_mem[i_waddr][l] <= i_wdata[8*l +: 8];
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - multi-cycle byte-addressable data memory with CPU stall handshake
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_count;
  logic                  r_is_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  w_req;
  logic                  w_start;
  logic                  w_last;
  logic [3:0]            w_we;
  logic [ADDR_WIDTH-3:0] w_raddr;
  logic [31:0]           w_rword;
  logic                  w_unused;

  assign w_req   = READ[READ_REQ_BIT] | WRITE[WRITE_REQ_BIT];
  assign w_start = (r_state == S_IDLE) && w_req;
  assign w_last  = (r_state == S_BUSY) && (r_count == 4'd0);
  assign w_we    = (w_last && r_is_write && !RESET) ? lane_mask(r_funct3[1:0], r_addr[1:0]) : 4'b0000;
  // In IDLE the array is pointed at the live address so data is ready even when LATENCY is 1.
  assign w_raddr = (r_state == S_IDLE) ? ADDRESS[ADDR_WIDTH-1:2] : r_addr[ADDR_WIDTH-1:2];
  assign w_unused = ^ADDRESS[31:ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = S_BUSY;
      S_BUSY:  if (r_count == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      case (r_state)
        S_IDLE:  BUSYWAIT = w_req;
        S_BUSY:  BUSYWAIT = 1'b1;
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end

  // A simultaneous read/write request is recorded as a write only.
  always_ff @(posedge CLK) begin
    if (w_start && !RESET) begin
      r_is_write <= WRITE[WRITE_REQ_BIT];
      r_funct3   <= WRITE[WRITE_REQ_BIT] ? {1'b0, WRITE[1:0]} : READ[2:0];
      r_addr     <= ADDRESS[ADDR_WIDTH-1:0];
      r_wdata    <= WRITE_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count   <= 4'd0;
      READ_DATA <= 32'h0;
    end else begin
      if (w_start) r_count <= CNT_LOAD;
      else if (r_state == S_BUSY && r_count != 4'd0) r_count <= r_count - 4'd1;
      if (w_last && !r_is_write) READ_DATA <= load_extend(r_funct3, r_addr[1:0], w_rword);
    end
  end

  data_memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .i_clk  (CLK),
    .i_waddr(r_addr[ADDR_WIDTH-1:2]),
    .i_we   (w_we),
    .i_wdata(store_lanes(r_funct3[1:0], r_wdata)),
    .i_raddr(w_raddr),
    .o_rdata(w_rword)
  );

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory
module tb_data_memory;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam int EXP_BUSY = 5;

  data_memory #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Runs one access; busy = -1 if DONE never arrives. With hold the request stays up through the DONE edge.
  task automatic run_access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                            input logic [31:0] wd, input bit hold, output int busy,
                            output logic [31:0] rdata);
    int n;
    n = 0;
    busy = 0;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITE_DATA = wd;
    #1;
    while (BUSYWAIT === 1'b1 && n < 40) begin
      busy++;
      n++;
      @(posedge CLK);
      #1;
      if (!hold) begin
        READ = 4'($urandom); WRITE = 3'($urandom); ADDRESS = $urandom; WRITE_DATA = $urandom;
      end
      @(negedge CLK);
    end
    if (n >= 40) busy = -1;
    rdata = READ_DATA;
    if (hold) begin
      @(posedge CLK);
      #1;
    end
    READ = 4'h0; WRITE = 3'h0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 4'b1010; WRITE = 3'h0; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
    checks++;
    if (READ_DATA !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 00000000", READ_DATA); end
    READ = 4'h0;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL idle_busywait got %b want 0", BUSYWAIT); end
  endtask

  task automatic test_word();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    run_access(4'h0, 3'b110, 32'h10, 32'hDEADBEEF, 1'b0, busy, rd);
    checks++;
    if (busy !== EXP_BUSY) begin errors++; $display("FAIL sw_busy_cycles got %0d want %0d", busy, EXP_BUSY); end
    exp_q.push_back(32'hDEADBEEF);
    run_access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0, busy, rd);
    checks++;
    if (busy !== EXP_BUSY) begin errors++; $display("FAIL lw_busy_cycles got %0d want %0d", busy, EXP_BUSY); end
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL lw_word got %h want %h", rd, exp); end
  endtask

  task automatic test_load_extend();
    logic [3:0]  ops  [6] = '{4'b1000, 4'b1100, 4'b1001, 4'b1101, 4'b1000, 4'b1011};
    logic [31:0] adrs [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h13};
    logic [31:0] exps [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                              32'hFFFFFFEF, 32'hDEADBEEF};
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      run_access(ops[i], 3'h0, adrs[i], 32'h0, 1'b0, busy, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL load_ext[%0d] got %h want %h", i, rd, exp); end
    end
  endtask

  task automatic test_partial_store();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    run_access(4'h0, 3'b100, 32'h11, 32'h12345677, 1'b0, busy, rd);
    exp_q.push_back(32'hDEAD77EF);
    run_access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL sb_merge got %h want %h", rd, exp); end
    run_access(4'h0, 3'b101, 32'h13, 32'hAAAA5555, 1'b0, busy, rd);
    exp_q.push_back(32'h555577EF);
    run_access(4'b1010, 3'h0, 32'h10, 32'h0, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL sh_merge got %h want %h", rd, exp); end
  endtask

  task automatic test_simultaneous();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    exp_q.push_back(32'h555577EF);
    run_access(4'b1010, 3'b110, 32'h20, 32'h1, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL both_read_data_held got %h want %h", rd, exp); end
    exp_q.push_back(32'h00000001);
    run_access(4'b1010, 3'h0, 32'h20, 32'h0, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL both_write_committed got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_abort();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    run_access(4'h0, 3'b110, 32'h30, 32'h0BADF00D, 1'b0, busy, rd);
    @(negedge CLK);
    READ = 4'h0; WRITE = 3'b110; ADDRESS = 32'h30; WRITE_DATA = 32'hFFFFFFFF;
    @(negedge CLK);
    WRITE = 3'h0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL abort_busywait got %b want 0", BUSYWAIT); end
    checks++;
    if (READ_DATA !== 32'h0) begin errors++; $display("FAIL abort_read_data got %h want 00000000", READ_DATA); end
    repeat (6) @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got %b want 0", BUSYWAIT); end
    exp_q.push_back(32'h0BADF00D);
    run_access(4'b1010, 3'h0, 32'h30, 32'h0, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL abort_contents got %h want %h", rd, exp); end
  endtask

  task automatic test_wrap_and_hold();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    exp_q.push_back(32'h555577EF);
    run_access(4'b1010, 3'h0, 32'h410, 32'h0, 1'b0, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL wrap_0x410 got %h want %h", rd, exp); end
    exp_q.push_back(32'hDEAD77EF);
    run_access(4'b1000, 3'h0, 32'h10, 32'h0, 1'b1, busy, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp[31:0] && rd !== 32'hFFFFFFEF) begin end
    if (rd !== 32'hFFFFFFEF) begin errors++; $display("FAIL hold_lb got %h want ffffffef", rd); end
    checks++;
    if (busy !== EXP_BUSY) begin errors++; $display("FAIL hold_busy_cycles got %0d want %0d", busy, EXP_BUSY); end
    @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL hold_single_access got %b want 0", BUSYWAIT); end
  endtask

  task automatic test_back_to_back();
    int busy;
    logic [31:0] rd;
    logic [31:0] exp;
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      a = 32'h100 + 32'(i * 12);
      d = $urandom;
      run_access(4'h0, 3'b111, a, d, 1'b0, busy, rd);
      exp_q.push_back(d);
      run_access(4'b1111, 3'h0, a | 32'h3, 32'h0, 1'b0, busy, rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, rd, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_load_extend();
    test_partial_store();
    test_simultaneous();
    test_reset_abort();
    test_wrap_and_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
